// File: rtl/gc_sched.sv
// gc_sched: per-queue eligibility (fill level, time gate, token bucket) and
// one-hot grant issue to the transmit scheduler, one packet at a time.
// Build option: define GC_RR_EN for round-robin selection starting after the
// last granted queue; leave it undefined for strict lowest-index priority.
module gc_sched #(
  parameter int unsigned NQ     = 4,
  parameter int unsigned NP     = 2,
  parameter int unsigned UW     = 8,
  parameter int unsigned UTH    = 20,
  parameter int unsigned TBW    = 12,
  parameter int unsigned TBSIZE = 2047,
  parameter int unsigned TBPER  = 100,
  localparam int unsigned PW    = (NP > 1) ? $clog2(NP) : 1,
  localparam int unsigned GW    = (NQ > 1) ? $clog2(NQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NQ*PW-1:0]  in_gc_md_outport,
  input  logic [NQ-1:0]     in_gc_fifo_empty,
  input  logic [NQ*7-1:0]   in_gc_pkt_len,
  input  logic [NQ-1:0]     in_gc_gate_open,
  input  logic [NQ-1:0]     in_gc_shaped,
  input  logic [NQ*TBW-1:0] in_gc_rate_limit,
  input  logic              in_gc_pkt_valid,
  input  logic [NP*UW-1:0]  pktout_usedw,
  input  logic [NQ-1:0]     in_gc_rden,
  output logic [NQ-1:0]     out_gc_schedule_valid,
  output logic [GW-1:0]     out_gc_grant_q
);

  localparam int unsigned SW = TBW + 8;
  localparam int unsigned CW = (TBPER > 1) ? $clog2(TBPER) : 1;

  typedef enum logic [1:0] {S_IDLE, S_JUDGE, S_GRANT, S_WAIT} state_t;

  state_t           state;
  logic             init_flag;
  logic [GW-1:0]    sel_q;
  logic [GW-1:0]    pick;
  logic [CW-1:0]    per_cnt;
  logic             wrap;
  logic [TBW-1:0]   rt     [NQ];
  logic [TBW-1:0]   rt_nxt [NQ];
  logic [SW-1:0]    tk_need [NQ];
  logic [SW-1:0]    tk_sum  [NQ];
  logic [SW-1:0]    tk_sub  [NQ];
  logic [SW-1:0]    tk_val  [NQ];
  logic [NQ-1:0]    port_ok;
  logic [NQ-1:0]    tok_ok;
  logic [NQ-1:0]    elig;

  assign wrap = (per_cnt == CW'(TBPER - 1));

  // Output port has room when its FIFO fill level is at or below threshold
  always_comb begin
    port_ok = '0;
    for (int unsigned q = 0; q < NQ; q++) begin
      for (int unsigned p = 0; p < NP; p++) begin
        if (in_gc_md_outport[q*PW +: PW] == PW'(p)) begin
          port_ok[q] = (pktout_usedw[p*UW +: UW] <= UW'(UTH));
        end
      end
    end
  end

  // Token bucket arithmetic: refill on wrap, consume on read start, clamp
  always_comb begin
    tok_ok = '0;
    for (int unsigned q = 0; q < NQ; q++) begin
      tk_need[q] = SW'(in_gc_pkt_len[q*7 +: 7]) << 4;
      tk_sum[q]  = SW'(rt[q]) + (wrap ? SW'(in_gc_rate_limit[q*TBW +: TBW]) : SW'(0));
      tk_sub[q]  = in_gc_rden[q] ? tk_need[q] : SW'(0);
      tk_val[q]  = (tk_sum[q] < tk_sub[q]) ? SW'(0) : (tk_sum[q] - tk_sub[q]);
      if (tk_val[q] > SW'(TBSIZE)) begin
        tk_val[q] = SW'(TBSIZE);
      end
      rt_nxt[q]  = TBW'(tk_val[q]);
      tok_ok[q]  = !in_gc_shaped[q] || (SW'(rt[q]) >= tk_need[q]);
    end
  end

  assign elig = ~in_gc_fifo_empty & in_gc_gate_open & port_ok & tok_ok;

`ifdef GC_RR_EN
  // Round-robin: first eligible queue above the last grant, wrapping
  always_comb begin
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NQ; i++) begin
      idx = (int unsigned'(out_gc_grant_q) + 1 + i) % NQ;
      if (!found && elig[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end
`else
  // Strict priority: lowest eligible index wins
  always_comb begin
    pick = '0;
    for (int i = int'(NQ) - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick = GW'(i);
      end
    end
  end
`endif

  // Shared refill period counter and per-queue token registers
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= '0;
      for (int unsigned q = 0; q < NQ; q++) begin
        rt[q] <= '0;
      end
    end else begin
      per_cnt <= wrap ? '0 : per_cnt + CW'(1);
      for (int unsigned q = 0; q < NQ; q++) begin
        rt[q] <= rt_nxt[q];
      end
    end
  end

  // Grant FSM: judge eligibility, pulse the grant, wait for packet completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= S_IDLE;
      init_flag             <= 1'b1;
      sel_q                 <= '0;
      out_gc_schedule_valid <= '0;
      out_gc_grant_q        <= '0;
    end else begin
      out_gc_schedule_valid <= '0;
      case (state)
        S_IDLE: begin
          if (init_flag || in_gc_pkt_valid) begin
            state <= S_JUDGE;
          end
        end
        S_JUDGE: begin
          if (|elig) begin
            sel_q <= pick;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          out_gc_schedule_valid <= NQ'(1) << sel_q;
          out_gc_grant_q        <= sel_q;
          init_flag             <= 1'b0;
          state                 <= S_WAIT;
        end
        S_WAIT: begin
          if (in_gc_pkt_valid) begin
            state <= S_JUDGE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
